// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding modes, flag bit positions, packing constants
// and the normalized-operand packet handed from fpu_norm to fpu_round.
package fpu_pkg;

    // RISC-V rm encoding; 101-111 are not listed and fall back to RNE downstream.
    typedef enum logic [2:0] {
        RmRne = 3'b000,
        RmRtz = 3'b001,
        RmRdn = 3'b010,
        RmRup = 3'b011,
        RmRmm = 3'b100
    } rm_e;

    // Bit positions inside the 5-bit {NV,DZ,OF,UF,NX} flag vector.
    localparam int unsigned FlagNv = 4;
    localparam int unsigned FlagDz = 3;
    localparam int unsigned FlagOf = 2;
    localparam int unsigned FlagUf = 1;
    localparam int unsigned FlagNx = 0;

    localparam logic [31:0] Qnan         = 32'h7FC0_0000;
    localparam logic [7:0]  InfExp       = 8'hFF;
    localparam logic [30:0] MaxFiniteMag = 31'h7F7F_FFFF;
    localparam int unsigned ExpBias      = 127;

    typedef struct packed {
        logic        sign;
        logic [9:0]  exp;   // biased, two's complement
        logic [26:0] mant;  // [26] hidden, [25:3] fraction, [2] G, [1] R, [0] S
        logic        nan;
        logic        inf;
        logic        zero;
        logic        nv;
    } norm_pkt_t;

endpackage

// File: rtl/fpu_round_inc.sv
// Round-increment decision and inexact detection for one normalized operand.
module fpu_round_inc
    import fpu_pkg::*;
(
    input  logic       sign_i,
    input  logic [2:0] rm_i,
    input  logic       lsb_i,
    input  logic [2:0] grs_i,
    input  logic       finite_i,
    output logic       inc_o,
    output logic       nx_o
);

    logic g, r, s;

    assign g = grs_i[2];
    assign r = grs_i[1];
    assign s = grs_i[0];

    // Per-mode increment; unlisted encodings behave as round-to-nearest-even.
    always_comb begin
        inc_o = 1'b0;
        case (rm_i)
            RmRtz:   inc_o = 1'b0;
            RmRdn:   inc_o = sign_i & (g | r | s);
            RmRup:   inc_o = ~sign_i & (g | r | s);
            RmRmm:   inc_o = g;
            default: inc_o = g & (r | s | lsb_i);
        endcase
    end

    assign nx_o = finite_i & (g | r | s);

endmodule

// File: rtl/fpu_round.sv
// Two-stage round/pack pipeline with valid/ready handshake and sticky fflags.
// S1 rounds and registers; S2 packs the IEEE single result and per-op flags.
module fpu_round
    import fpu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        norm_valid_i,
    output logic        norm_ready_o,
    input  logic        norm_sign_i,
    input  logic [9:0]  norm_exp_i,
    input  logic [26:0] norm_mant_i,
    input  logic        norm_nan_i,
    input  logic        norm_inf_i,
    input  logic        norm_zero_i,
    input  logic        norm_nv_i,
    input  logic [2:0]  rm_i,
    output logic        res_valid_o,
    input  logic        res_ready_i,
    output logic [31:0] res_data_o,
    output logic [4:0]  res_flags_o,
    input  logic        fflags_clr_i,
    output logic [4:0]  fflags_o
);

    norm_pkt_t in_pkt;

    // Gather the upstream fields into the shared packet type.
    always_comb begin
        in_pkt.sign = norm_sign_i;
        in_pkt.exp  = norm_exp_i;
        in_pkt.mant = norm_mant_i;
        in_pkt.nan  = norm_nan_i;
        in_pkt.inf  = norm_inf_i;
        in_pkt.zero = norm_zero_i;
        in_pkt.nv   = norm_nv_i;
    end

    logic s1_valid_q, s2_valid_q;
    logic s1_adv, s2_adv, in_fire, out_fire;

    assign s2_adv       = ~s2_valid_q | res_ready_i;
    assign s1_adv       = ~s1_valid_q | s2_adv;
    assign norm_ready_o = s1_adv;
    assign in_fire      = norm_valid_i & s1_adv;
    assign out_fire     = s2_valid_q & res_ready_i;

    logic               inc, nx, finite;
    logic [24:0]        mant_rnd;
    logic signed [10:0] exp_rnd;

    assign finite = ~(in_pkt.nan | in_pkt.inf | in_pkt.zero);

    fpu_round_inc u_inc (
        .sign_i   (in_pkt.sign),
        .rm_i     (rm_i),
        .lsb_i    (in_pkt.mant[3]),
        .grs_i    (in_pkt.mant[2:0]),
        .finite_i (finite),
        .inc_o    (inc),
        .nx_o     (nx)
    );

    // Carry-out in bit 24 bumps the exponent; the matching right shift happens at pack.
    assign mant_rnd = {1'b0, in_pkt.mant[26:3]} + {24'd0, inc};
    assign exp_rnd  = {in_pkt.exp[9], in_pkt.exp} + {10'd0, mant_rnd[24]};

    logic               s1_sign_q, s1_nan_q, s1_inf_q, s1_zero_q, s1_nv_q, s1_nx_q;
    logic signed [10:0] s1_exp_q;
    logic [24:0]        s1_mant_q;
    logic [2:0]         s1_rm_q;

    // S1: capture the rounded operand on an input handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_mant_q  <= '0;
            s1_nan_q   <= 1'b0;
            s1_inf_q   <= 1'b0;
            s1_zero_q  <= 1'b0;
            s1_nv_q    <= 1'b0;
            s1_nx_q    <= 1'b0;
            s1_rm_q    <= '0;
        end else begin
            if (s1_adv) s1_valid_q <= norm_valid_i;
            if (in_fire) begin
                s1_sign_q <= in_pkt.sign;
                s1_exp_q  <= exp_rnd;
                s1_mant_q <= mant_rnd;
                s1_nan_q  <= in_pkt.nan;
                s1_inf_q  <= in_pkt.inf;
                s1_zero_q <= in_pkt.zero;
                s1_nv_q   <= in_pkt.nv;
                s1_nx_q   <= nx;
                s1_rm_q   <= rm_i;
            end
        end
    end

    logic        ovf, unf, max_fin;
    logic [22:0] frac;
    logic [31:0] pack_data;
    logic [4:0]  pack_flags;

    assign ovf     = (s1_exp_q >= 11'sd255);
    assign unf     = (s1_exp_q <= 11'sd0);
    assign frac    = s1_mant_q[24] ? s1_mant_q[23:1] : s1_mant_q[22:0];
    // Modes rounding toward zero for this sign saturate to max finite instead of inf.
    assign max_fin = (s1_rm_q == RmRtz) | ((s1_rm_q == RmRdn) & ~s1_sign_q) |
                     ((s1_rm_q == RmRup) & s1_sign_q);

    // Pack the S1 contents into an IEEE single result and its flags.
    always_comb begin
        pack_data          = {s1_sign_q, s1_exp_q[7:0], frac};
        pack_flags         = '0;
        pack_flags[FlagNv] = s1_nv_q;
        if (s1_nan_q) begin
            pack_data = Qnan;
        end else if (s1_inf_q) begin
            pack_data = {s1_sign_q, InfExp, 23'd0};
        end else if (s1_zero_q) begin
            pack_data = {s1_sign_q, 31'd0};
        end else if (ovf) begin
            pack_data          = max_fin ? {s1_sign_q, MaxFiniteMag} : {s1_sign_q, InfExp, 23'd0};
            pack_flags[FlagOf] = 1'b1;
            pack_flags[FlagNx] = 1'b1;
        end else if (unf) begin
            pack_data          = {s1_sign_q, 31'd0};
            pack_flags[FlagUf] = 1'b1;
            pack_flags[FlagNx] = 1'b1;
        end else begin
            pack_flags[FlagNx] = s1_nx_q;
        end
    end

    logic [31:0] res_data_q;
    logic [4:0]  res_flags_q;

    // S2: result register, held while downstream stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s2_valid_q  <= 1'b0;
            res_data_q  <= '0;
            res_flags_q <= '0;
        end else if (s2_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                res_data_q  <= pack_data;
                res_flags_q <= pack_flags;
            end
        end
    end

    assign res_valid_o = s2_valid_q;
    assign res_data_o  = res_data_q;
    assign res_flags_o = res_flags_q;

    logic [4:0] fflags_d, fflags_q;

    // Clear wins over the old contents but not over the op retiring in the same cycle.
    always_comb begin
        fflags_d = fflags_q;
        if (fflags_clr_i) fflags_d = '0;
        if (out_fire) fflags_d = fflags_d | res_flags_q;
    end

    // Sticky flag accumulator.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) fflags_q <= '0;
        else         fflags_q <= fflags_d;
    end

    assign fflags_o = fflags_q;

endmodule

// File: tb/tb_fpu_round.sv
// Scoreboard bench for fpu_round: directed vectors push expected results,
// a negedge monitor pops and compares on each output handshake.
module tb_fpu_round;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        norm_valid_i, norm_ready_o, norm_sign_i;
    logic [9:0]  norm_exp_i;
    logic [26:0] norm_mant_i;
    logic        norm_nan_i, norm_inf_i, norm_zero_i, norm_nv_i;
    logic [2:0]  rm_i;
    logic        res_valid_o, res_ready_i;
    logic [31:0] res_data_o;
    logic [4:0]  res_flags_o;
    logic        fflags_clr_i;
    logic [4:0]  fflags_o;

    fpu_round dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .norm_valid_i (norm_valid_i),
        .norm_ready_o (norm_ready_o),
        .norm_sign_i  (norm_sign_i),
        .norm_exp_i   (norm_exp_i),
        .norm_mant_i  (norm_mant_i),
        .norm_nan_i   (norm_nan_i),
        .norm_inf_i   (norm_inf_i),
        .norm_zero_i  (norm_zero_i),
        .norm_nv_i    (norm_nv_i),
        .rm_i         (rm_i),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .res_data_o   (res_data_o),
        .res_flags_o  (res_flags_o),
        .fflags_clr_i (fflags_clr_i),
        .fflags_o     (fflags_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] d;
        logic [4:0]  f;
        string       n;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_checks = 0;
    int          n_pass   = 0;
    logic        held     = 1'b0;
    logic [31:0] held_d;
    logic [4:0]  held_f;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Monitor: compare each retired result and check stability under stall.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            held = 1'b0;
        end else begin
            if (res_valid_o && held) begin
                check("hold_data", res_data_o, held_d);
                check("hold_flags", {27'd0, res_flags_o}, {27'd0, held_f});
            end
            if (res_valid_o && res_ready_i) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_output: got 0x%08h, expected none", res_data_o);
                end else begin
                    e = sb.pop_front();
                    check({e.n, "_data"}, res_data_o, e.d);
                    check({e.n, "_flags"}, {27'd0, res_flags_o}, {27'd0, e.f});
                end
                held = 1'b0;
            end else if (res_valid_o) begin
                held   = 1'b1;
                held_d = res_data_o;
                held_f = res_flags_o;
            end else begin
                held = 1'b0;
            end
        end
    end

    // Offer one op (called at posedge+1); returns at posedge+1 after its handshake.
    task automatic send(input string n, input logic s, input logic [9:0] ex, input logic [26:0] m,
                        input logic [2:0] rm, input logic [2:0] cls, input logic nv,
                        input logic [31:0] xd, input logic [4:0] xf);
        exp_t x;
        bit   done = 1'b0;
        norm_valid_i = 1'b1;
        norm_sign_i  = s;
        norm_exp_i   = ex;
        norm_mant_i  = m;
        rm_i         = rm;
        {norm_nan_i, norm_inf_i, norm_zero_i} = cls;
        norm_nv_i    = nv;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk_i);
            if (norm_ready_o) begin
                x.d = xd;
                x.f = xf;
                x.n = n;
                sb.push_back(x);
                done = 1'b1;
            end
            @(posedge clk_i);
            #1;
        end
        if (!done) begin
            n_checks++;
            $display("FAIL %s_accept: got no handshake in 20 cycles, expected one", n);
        end
        norm_valid_i = 1'b0;
        rm_i         = 3'b111;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    localparam logic [26:0] AllOnesG = 27'h7FF_FFFC;

    initial begin
        rst_ni       = 1'b0;
        norm_valid_i = 1'b0;
        norm_sign_i  = 1'b0;
        norm_exp_i   = '0;
        norm_mant_i  = '0;
        norm_nan_i   = 1'b0;
        norm_inf_i   = 1'b0;
        norm_zero_i  = 1'b0;
        norm_nv_i    = 1'b0;
        rm_i         = 3'b000;
        res_ready_i  = 1'b1;
        fflags_clr_i = 1'b0;
        cycles(2);
        check("rst_valid", {31'd0, res_valid_o}, 32'd0);
        check("rst_data", res_data_o, 32'd0);
        check("rst_flags", {27'd0, res_flags_o}, 32'd0);
        check("rst_fflags", {27'd0, fflags_o}, 32'd0);
        check("rst_ready", {31'd0, norm_ready_o}, 32'd1);
        rst_ni = 1'b1;
        cycles(1);

        // Exact value and two-cycle latency.
        send("exact", 1'b0, 10'd127, 27'h600_0000, 3'b000, 3'b000, 1'b0, 32'h3FC0_0000, 5'h00);
        check("lat_cycle1", {31'd0, res_valid_o}, 32'd0);
        cycles(1);
        check("lat_cycle2", {31'd0, res_valid_o}, 32'd1);

        // Rounding modes, back to back.
        send("carry_rne", 1'b0, 10'd127, AllOnesG, 3'b000, 3'b000, 1'b0, 32'h4000_0000, 5'h01);
        send("carry_rtz", 1'b0, 10'd127, AllOnesG, 3'b001, 3'b000, 1'b0, 32'h3FFF_FFFF, 5'h01);
        send("tie_even", 1'b0, 10'd127, 27'h400_0004, 3'b000, 3'b000, 1'b0, 32'h3F80_0000, 5'h01);
        send("tie_odd_rm5", 1'b0, 10'd127, 27'h400_000C, 3'b101, 3'b000, 1'b0, 32'h3F80_0002, 5'h01);
        send("rmm_tie", 1'b0, 10'd127, 27'h400_0004, 3'b100, 3'b000, 1'b0, 32'h3F80_0001, 5'h01);
        send("rdn_neg", 1'b1, 10'd127, 27'h400_0001, 3'b010, 3'b000, 1'b0, 32'hBF80_0001, 5'h01);
        send("rup_pos", 1'b0, 10'd127, 27'h400_0001, 3'b011, 3'b000, 1'b0, 32'h3F80_0001, 5'h01);
        send("rup_neg", 1'b1, 10'd127, 27'h400_0001, 3'b011, 3'b000, 1'b0, 32'hBF80_0000, 5'h01);

        // Overflow boundary: only a rounding carry out of exp 254 overflows.
        send("ovf_rne", 1'b0, 10'd254, AllOnesG, 3'b000, 3'b000, 1'b0, 32'h7F80_0000, 5'h05);
        send("top_rtz", 1'b0, 10'd254, AllOnesG, 3'b001, 3'b000, 1'b0, 32'h7F7F_FFFF, 5'h01);
        send("top_rup_neg", 1'b1, 10'd254, AllOnesG, 3'b011, 3'b000, 1'b0, 32'hFF7F_FFFF, 5'h01);
        send("ovf_rtz", 1'b0, 10'd255, 27'h400_0000, 3'b001, 3'b000, 1'b0, 32'h7F7F_FFFF, 5'h05);
        send("ovf_rdn_pos", 1'b0, 10'd300, 27'h400_0000, 3'b010, 3'b000, 1'b0, 32'h7F7F_FFFF, 5'h05);
        send("ovf_rdn_neg", 1'b1, 10'd300, 27'h400_0000, 3'b010, 3'b000, 1'b0, 32'hFF80_0000, 5'h05);
        cycles(4);

        // Backpressure: two ops fill the pipe, the third waits for release.
        res_ready_i = 1'b0;
        send("bp_a", 1'b0, 10'd128, 27'h400_0000, 3'b000, 3'b000, 1'b0, 32'h4000_0000, 5'h00);
        send("bp_b", 1'b0, 10'd129, 27'h400_0000, 3'b001, 3'b000, 1'b0, 32'h4080_0000, 5'h00);
        fork
            send("bp_c", 1'b0, 10'd130, 27'h400_0000, 3'b000, 3'b000, 1'b0, 32'h4100_0000, 5'h00);
            begin
                @(negedge clk_i);
                check("bp_ready_low", {31'd0, norm_ready_o}, 32'd0);
                check("bp_valid", {31'd0, res_valid_o}, 32'd1);
                cycles(2);
                res_ready_i = 1'b1;
            end
        join
        cycles(4);
        check("bp_drained", sb.size(), 32'd0);

        // Sticky flags.
        fflags_clr_i = 1'b1;
        cycles(1);
        fflags_clr_i = 1'b0;
        check("fflags_cleared", {27'd0, fflags_o}, 32'd0);
        send("nan_nv", 1'b0, 10'd0, 27'd0, 3'b000, 3'b100, 1'b1, 32'h7FC0_0000, 5'h10);
        cycles(3);
        check("fflags_nv", {27'd0, fflags_o}, 32'h10);
        send("nx_clr", 1'b0, 10'd127, AllOnesG, 3'b001, 3'b000, 1'b0, 32'h3FFF_FFFF, 5'h01);
        cycles(1);
        fflags_clr_i = 1'b1;
        cycles(1);
        fflags_clr_i = 1'b0;
        check("fflags_clr_and_op", {27'd0, fflags_o}, 32'h01);

        // Underflow and special classes.
        send("unf_exp0", 1'b0, 10'd0, 27'h400_0000, 3'b000, 3'b000, 1'b0, 32'h0000_0000, 5'h03);
        send("unf_neg", 1'b1, 10'h3FB, 27'h400_0000, 3'b001, 3'b000, 1'b0, 32'h8000_0000, 5'h03);
        send("zero_neg", 1'b1, 10'd50, 27'h7FF_FFFF, 3'b011, 3'b001, 1'b0, 32'h8000_0000, 5'h00);
        send("inf_neg", 1'b1, 10'd50, 27'h7FF_FFFF, 3'b000, 3'b010, 1'b0, 32'hFF80_0000, 5'h00);
        cycles(4);
        check("fflags_accum", {27'd0, fflags_o}, 32'h03);

        // Asynchronous reset with both stages occupied.
        res_ready_i = 1'b0;
        send("rst_a", 1'b0, 10'd128, 27'h400_0000, 3'b000, 3'b000, 1'b0, 32'h4000_0000, 5'h00);
        send("rst_b", 1'b0, 10'd129, 27'h400_0000, 3'b000, 3'b000, 1'b0, 32'h4080_0000, 5'h00);
        check("pre_rst_ready", {31'd0, norm_ready_o}, 32'd0);
        rst_ni = 1'b0;
        #1;
        check("arst_valid", {31'd0, res_valid_o}, 32'd0);
        check("arst_fflags", {27'd0, fflags_o}, 32'd0);
        check("arst_ready", {31'd0, norm_ready_o}, 32'd1);
        sb.delete();
        cycles(1);
        rst_ni      = 1'b1;
        res_ready_i = 1'b1;
        cycles(2);
        check("post_rst_valid", {31'd0, res_valid_o}, 32'd0);
        send("post_rst", 1'b0, 10'd127, 27'h600_0000, 3'b000, 3'b000, 1'b0, 32'h3FC0_0000, 5'h00);

        for (int i = 0; i < 20 && sb.size() != 0; i++) cycles(1);
        check("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
